seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width, legal range 2..32.
REQ-002 SHALL have parameter SIGNED_EN, default 1: when 0, sign_mode is ignored and all divisions are unsigned.
REQ-003 SHALL have port clk  input  1  the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-006 SHALL have port sign_mode  input  1  1 = two's-complement operands; sampled with start.
REQ-007 SHALL have port dividend  input  WIDTH  numerator; sampled with start.
REQ-008 SHALL have port divisor  input  WIDTH  denominator; sampled with start.
REQ-009 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-011 SHALL have ports quotient and remainder  output  WIDTH each  registered results.
REQ-012 SHALL have port div_by_zero  output  1  the last operation had divisor == 0.
REQ-013 SHALL have port ovf  output  1  the last operation was signed most-negative / -1.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE; IDLE->CALC on start, CALC->FIX after WIDTH iterations, FIX->DONE, DONE->IDLE unconditionally.
REQ-015 SHALL, on acceptance, latch operand magnitudes (absolute values when signed), the two sign bits and the zero-divisor condition, then clear the partial remainder.
REQ-016 SHALL perform one restoring iteration per CALC cycle: shift {rem,quo} left 1, trial-subtract the divisor magnitude (WIDTH+1-bit), set the quotient LSB to 1 and keep the difference if non-negative, otherwise set the LSB to 0 and restore.
REQ-017 SHALL apply sign correction in FIX: the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign, giving truncation toward zero.
REQ-018 SHALL assert done for exactly one cycle, WIDTH+2 rising edges after the edge that accepted start; busy SHALL fall on that same edge.
REQ-019 SHALL keep latency constant for every operand value, including the zero-divisor and overflow cases.
REQ-020 SHALL, for divisor == 0, return quotient all-ones, remainder = dividend unchanged, div_by_zero=1, ovf=0.
REQ-021 SHALL, for signed most-negative / -1, return quotient = most-negative value, remainder 0, ovf=1.
REQ-022 SHALL hold quotient, remainder, div_by_zero and ovf stable from done until the next done.
REQ-023 SHALL ignore start while busy or in DONE; no queueing.
REQ-024 SHALL accept a start asserted in the cycle immediately after done (back-to-back operation).

Reset
REQ-025 SHALL, with rst_n low at a rising edge, enter IDLE and clear busy, done, quotient, remainder, div_by_zero, ovf and the iteration counter to 0.
REQ-026 SHALL abort any in-progress division on reset without producing done, including reset asserted mid-CALC.
REQ-027 SHALL ignore start in any cycle where rst_n is low.

Structure
REQ-028 SHALL take the FSM state enum and the iteration-counter width constant ($clog2(WIDTH+1)) from shared package div_pkg.
REQ-029 SHALL place one restoring step (shift, trial-subtract, select) in combinational sub-module div_step, instantiated once.

Verification
REQ-030 SHALL cover, WIDTH=8 unsigned: 100/7 -> done at start+10, quotient 14, remainder 2, flags 0.
REQ-031 SHALL cover, signed: -100/7 -> quotient 0xF2, remainder 0xFE; 100/-7 -> quotient 0xF2, remainder 0x02.
REQ-032 SHALL cover 55/0 -> quotient 0xFF, remainder 0x37, div_by_zero=1, latency 10.
REQ-033 SHALL cover signed -128/-1 -> quotient 0x80, remainder 0, ovf=1.
REQ-034 SHALL cover start pulsed during busy (ignored), then start one cycle after done (accepted), and rst_n low at CALC iteration 4 (no done, all outputs 0, next start behaves normally).
REQ-035 SHALL run a randomised check at WIDTH=8 and WIDTH=16 comparing results against a reference model for both modes.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the sizing rule for the iteration counter.
package div_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // The counter has to hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor magnitude, keep the difference and set the quotient bit when it fits.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             keep;

    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        // rem_in < dvs holds between steps, so a set top bit always means the
        // divisor fits and the true difference never needs more than WIDTH bits.
        keep    = shifted[WIDTH] || (shifted[WIDTH-1:0] >= dvs);
        diff    = shifted[WIDTH-1:0] - dvs;
        rem_out = keep ? diff : shifted[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], keep};
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned restoring divider with fixed WIDTH+2 cycle latency,
// truncating toward zero, with divide-by-zero and signed-overflow flags.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ovf
);

    localparam int               CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("seq_divider: WIDTH must be in 2..32");
    end

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             zero_q, zero_d;
    logic             ovf_case_q, ovf_case_d;

    logic             signed_op;
    logic             in_sign_a;
    logic             in_sign_b;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in (rem_q),
        .quo_in (quo_q),
        .dvs    (dvs_q),
        .rem_out(step_rem),
        .quo_out(step_quo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        zero_d      = zero_q;
        ovf_case_d  = ovf_case_q;

        signed_op = (SIGNED_EN != 0) && sign_mode;
        in_sign_a = signed_op && dividend[WIDTH-1];
        in_sign_b = signed_op && divisor[WIDTH-1];

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CALC;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    sign_a_d   = in_sign_a;
                    sign_b_d   = in_sign_b;
                    quo_d      = in_sign_a ? negate(dividend) : dividend;
                    dvs_d      = in_sign_b ? negate(divisor) : divisor;
                    rem_d      = '0;
                    zero_d     = (divisor == '0);
                    ovf_case_d = signed_op && (dividend == MOST_NEG) && (divisor == '1);
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // A zero divisor leaves rem equal to |dividend|, so re-applying the
                // dividend sign restores the original operand. MOST_NEG / -1 already
                // yields MOST_NEG r 0 from the magnitude path and needs no override.
                if (zero_q) begin
                    quo_d = '1;
                end else if (sign_a_q ^ sign_b_q) begin
                    quo_d = negate(quo_q);
                end
                rem_d   = sign_a_q ? negate(rem_q) : rem_q;
                state_d = DONE;
            end
            DONE: begin
                quotient_d  = quo_q;
                remainder_d = rem_q;
                dbz_d       = zero_q;
                ovf_d       = ovf_case_q;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                cnt_d       = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    // Datapath working registers are always loaded before use, so no reset.
    always_ff @(posedge clk) begin
        rem_q      <= rem_d;
        quo_q      <= quo_d;
        dvs_q      <= dvs_d;
        sign_a_q   <= sign_a_d;
        sign_b_q   <= sign_b_d;
        zero_q     <= zero_d;
        ovf_case_q <= ovf_case_d;
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign ovf         = ovf_q;

endmodule
